td4_cpu_param: RTL and testbench

- Parametrised successor to the team's 4-bit TD4-style CPU.
- Data width and PC width are set by parameters.
- Instruction fetch goes through an external req/ack memory interface with wait-state support.
- Adds a zero flag, a JZ instruction, HLT with resume, and an output strobe.
- Sits between a program memory (ROM or RAM model) and a simple I/O port.

---
 rtl/td4_cpu_param.sv | 177 +++++++++++++++++
 tb/tb_td4_cpu_param.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/td4_cpu_param.sv
// Parametrised TD4-style CPU: FETCH/EXEC/HALT sequencer with a req/ack instruction
// port, carry and zero flags, JMP/JNC/JZ, HLT with resume and a one-cycle output strobe.
module td4_cpu_param #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [DATA_W+3:0] imem_data,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_strobe,
  input  logic              resume,
  output logic              halted,
  output logic [PC_W-1:0]   pc_out,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  localparam logic [3:0] OP_ADD_A   = 4'b0000;
  localparam logic [3:0] OP_MOV_AB  = 4'b0001;
  localparam logic [3:0] OP_IN_A    = 4'b0010;
  localparam logic [3:0] OP_MOV_A   = 4'b0011;
  localparam logic [3:0] OP_MOV_BA  = 4'b0100;
  localparam logic [3:0] OP_ADD_B   = 4'b0101;
  localparam logic [3:0] OP_IN_B    = 4'b0110;
  localparam logic [3:0] OP_MOV_B   = 4'b0111;
  localparam logic [3:0] OP_OUT_B   = 4'b1001;
  localparam logic [3:0] OP_JZ      = 4'b1010;
  localparam logic [3:0] OP_OUT_IMM = 4'b1011;
  localparam logic [3:0] OP_HLT     = 4'b1101;
  localparam logic [3:0] OP_JNC     = 4'b1110;
  localparam logic [3:0] OP_JMP     = 4'b1111;

  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_A    = 2'd1;
  localparam logic [1:0] SRC_B    = 2'd2;
  localparam logic [1:0] SRC_IN   = 2'd3;

  localparam logic [1:0] DST_A    = 2'd0;
  localparam logic [1:0] DST_B    = 2'd1;
  localparam logic [1:0] DST_OUT  = 2'd2;
  localparam logic [1:0] DST_NONE = 2'd3;

  logic [1:0]        state;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W+3:0] ir;
  logic              carry;
  logic              zero;
  logic              strobe_q;

  logic [3:0]        opcode;
  logic [DATA_W-1:0] imm;
  logic [1:0]        src_sel;
  logic [1:0]        dst_sel;
  logic              jump_taken;
  logic              is_hlt;
  logic [DATA_W-1:0] src_val;
  logic [DATA_W:0]   alu_sum;
  logic [DATA_W-1:0] alu_res;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   pc_next;

  assign opcode = ir[DATA_W+3:DATA_W];
  assign imm    = ir[DATA_W-1:0];

  // Every data-moving opcode is an add of some source to imm; MOV imm uses a zero source.
  always_comb begin
    src_sel    = SRC_ZERO;
    dst_sel    = DST_NONE;
    jump_taken = 1'b0;
    is_hlt     = 1'b0;
    case (opcode)
      OP_ADD_A:   begin src_sel = SRC_A;    dst_sel = DST_A;   end
      OP_MOV_AB:  begin src_sel = SRC_B;    dst_sel = DST_A;   end
      OP_IN_A:    begin src_sel = SRC_IN;   dst_sel = DST_A;   end
      OP_MOV_A:   begin src_sel = SRC_ZERO; dst_sel = DST_A;   end
      OP_MOV_BA:  begin src_sel = SRC_A;    dst_sel = DST_B;   end
      OP_ADD_B:   begin src_sel = SRC_B;    dst_sel = DST_B;   end
      OP_IN_B:    begin src_sel = SRC_IN;   dst_sel = DST_B;   end
      OP_MOV_B:   begin src_sel = SRC_ZERO; dst_sel = DST_B;   end
      OP_OUT_B:   begin src_sel = SRC_B;    dst_sel = DST_OUT; end
      OP_OUT_IMM: begin src_sel = SRC_ZERO; dst_sel = DST_OUT; end
      OP_JMP:     jump_taken = 1'b1;
      OP_JNC:     jump_taken = ~carry;
      OP_JZ:      jump_taken = zero;
      OP_HLT:     is_hlt = 1'b1;
      default:    ;
    endcase
  end

  always_comb begin
    src_val = '0;
    case (src_sel)
      SRC_A:   src_val = reg_a;
      SRC_B:   src_val = reg_b;
      SRC_IN:  src_val = in_data;
      default: src_val = '0;
    endcase
  end

  assign alu_sum = {1'b0, src_val} + {1'b0, imm};
  assign alu_res = alu_sum[DATA_W-1:0];
  assign pc_inc  = pc + PC_W'(1);
  assign pc_next = jump_taken ? imm[PC_W-1:0] : pc_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      ir    <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            ir    <= imem_data;
            state <= EXEC;
          end
        end
        EXEC:    state <= is_hlt ? HALT : FETCH;
        HALT:    if (resume) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // Architectural state only moves on the EXEC edge, so a reset anywhere else
  // leaves nothing half-written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= '0;
      reg_a    <= '0;
      reg_b    <= '0;
      out_q    <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (state == EXEC) begin
        pc <= pc_next;
        if (dst_sel != DST_NONE) begin
          carry <= alu_sum[DATA_W];
          zero  <= (alu_res == '0);
        end
        case (dst_sel)
          DST_A:   reg_a <= alu_res;
          DST_B:   reg_b <= alu_res;
          DST_OUT: begin
            out_q    <= alu_res;
            strobe_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_addr  = pc;
  assign imem_req   = (state == FETCH);
  assign halted     = (state == HALT);
  assign out_data   = out_q;
  assign out_strobe = strobe_q;
  assign pc_out     = pc;
  assign a_out      = reg_a;
  assign b_out      = reg_b;

endmodule

// File: tb/tb_td4_cpu_param.sv
// Bench for td4_cpu_param: a 4/4 and an 8/6 instance, each fed by a req/ack ROM model
// with programmable wait states, checked against an instruction-level reference model.
module tb_td4_cpu_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int pc;
    int a;
    int b;
    int out;
    bit c;
    bit z;
    bit strobe;
    bit halt;
  } arch_t;

  typedef struct {
    int         addr;
    logic [7:0] instr;
    logic [3:0] inp;
    int         exp_pc;
    int         exp_a;
    int         exp_b;
    int         exp_out;
    bit         exp_strobe;
  } vec_t;

  logic       reset4  = 1'b0;
  logic       resume4 = 1'b0;
  logic       ack4    = 1'b0;
  logic [7:0] data4   = '0;
  logic [3:0] in4     = '0;
  logic       req4, halted4, strobe4;
  logic [3:0] addr4, pc4, out4, a4, b4;
  logic [7:0] mem4 [16];
  int         wait4 = 0;
  int         cnt4  = 0;

  logic        reset8  = 1'b0;
  logic        resume8 = 1'b0;
  logic        ack8    = 1'b0;
  logic [11:0] data8   = '0;
  logic [7:0]  in8     = '0;
  logic        req8, halted8, strobe8;
  logic [5:0]  addr8, pc8;
  logic [7:0]  out8, a8, b8;
  logic [11:0] mem8 [64];
  int          wait8 = 0;
  int          cnt8  = 0;

  td4_cpu_param #(.DATA_W(4), .PC_W(4)) dut4 (
    .clk(clk), .reset(reset4), .imem_addr(addr4), .imem_req(req4), .imem_ack(ack4),
    .imem_data(data4), .in_data(in4), .out_data(out4), .out_strobe(strobe4),
    .resume(resume4), .halted(halted4), .pc_out(pc4), .a_out(a4), .b_out(b4)
  );

  td4_cpu_param #(.DATA_W(8), .PC_W(6)) dut8 (
    .clk(clk), .reset(reset8), .imem_addr(addr8), .imem_req(req8), .imem_ack(ack8),
    .imem_data(data8), .in_data(in8), .out_data(out8), .out_strobe(strobe8),
    .resume(resume8), .halted(halted8), .pc_out(pc8), .a_out(a8), .b_out(b8)
  );

  // ROM models: answer a request after waitN idle cycles, drive on the falling edge.
  always @(negedge clk) begin
    if (!reset4 || !req4) begin
      ack4 = 1'b0;
      cnt4 = 0;
    end else if (cnt4 >= wait4) begin
      ack4  = 1'b1;
      data4 = mem4[addr4];
    end else begin
      ack4 = 1'b0;
      cnt4++;
    end
  end

  always @(negedge clk) begin
    if (!reset8 || !req8) begin
      ack8 = 1'b0;
      cnt8 = 0;
    end else if (cnt8 >= wait8) begin
      ack8  = 1'b1;
      data8 = mem8[addr8];
    end else begin
      ack8 = 1'b0;
      cnt8++;
    end
  end

  // Instruction-level model: every data op is dst = (src + imm) mod 2^dw.
  function automatic arch_t ref_step(arch_t s, int op, int imm, int inp, int dw, int pw);
    arch_t n;
    int lim;
    int plim;
    int src;
    int dst;
    int sum;
    n      = s;
    lim    = 1 << dw;
    plim   = 1 << pw;
    src    = 0;
    dst    = -1;
    n.strobe = 1'b0;
    n.halt   = 1'b0;
    n.pc     = (s.pc + 1) % plim;
    case (op)
      0:  begin src = s.a; dst = 0; end
      1:  begin src = s.b; dst = 0; end
      2:  begin src = inp; dst = 0; end
      3:  begin src = 0;   dst = 0; end
      4:  begin src = s.a; dst = 1; end
      5:  begin src = s.b; dst = 1; end
      6:  begin src = inp; dst = 1; end
      7:  begin src = 0;   dst = 1; end
      9:  begin src = s.b; dst = 2; end
      11: begin src = 0;   dst = 2; end
      15: n.pc = imm % plim;
      14: if (!s.c) n.pc = imm % plim;
      10: if (s.z) n.pc = imm % plim;
      13: n.halt = 1'b1;
      default: ;
    endcase
    if (dst >= 0) begin
      sum = src + imm;
      n.c = (sum >= lim);
      n.z = ((sum % lim) == 0);
      case (dst)
        0: n.a = sum % lim;
        1: n.b = sum % lim;
        default: begin n.out = sum % lim; n.strobe = 1'b1; end
      endcase
    end
    return n;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_arch(input string tag, input logic [31:0] pc, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] o, input logic st,
                            input arch_t m);
    check_output({tag, "_pc"}, pc, m.pc);
    check_output({tag, "_a"}, a, m.a);
    check_output({tag, "_b"}, b, m.b);
    check_output({tag, "_out"}, o, m.out);
    check_output({tag, "_strobe"}, {31'b0, st}, {31'b0, m.strobe});
  endtask

  // Wait for the EXEC cycle (not fetching, not halted), then return just after its edge.
  task automatic step4();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (!req4 && !halted4) seen = 1'b1;
    end
    check_output("step4_exec_seen", {31'b0, seen}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic step8();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (!req8 && !halted8) seen = 1'b1;
    end
    check_output("step8_exec_seen", {31'b0, seen}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus_reset4();
    reset4 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset4 = 1'b1;
    #1;
    check_output("rst4_pc", pc4, 0);
    check_output("rst4_a", a4, 0);
    check_output("rst4_b", b4, 0);
    check_output("rst4_out", out4, 0);
    check_output("rst4_strobe", strobe4, 0);
    check_output("rst4_halted", halted4, 0);
    check_output("rst4_req", req4, 1);
    check_output("rst4_addr", addr4, 0);
  endtask

  task automatic apply_stimulus_reset8();
    reset8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset8 = 1'b1;
    #1;
    check_output("rst8_pc", pc8, 0);
    check_output("rst8_a", a8, 0);
    check_output("rst8_req", req8, 1);
    check_output("rst8_halted", halted8, 0);
  endtask

  // While a fetch is stalled nothing architectural may move.
  task automatic check_fetch_hold4(input int exp_pc, input int exp_a);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("hold_req", req4, 1);
      check_output("hold_addr", addr4, exp_pc);
      check_output("hold_pc", pc4, exp_pc);
      check_output("hold_a", a4, exp_a);
    end
  endtask

  task automatic run_carry_loop(input int wait_cycles);
    for (int k = 0; k < 16; k++) mem4[k] = 8'h80;
    mem4[0] = 8'h01;
    mem4[1] = 8'hE0;
    wait4 = wait_cycles;
    apply_stimulus_reset4();
    if (wait_cycles > 0) check_fetch_hold4(0, 0);
    step4();
    if (wait_cycles > 0) check_fetch_hold4(1, 1);
    for (int k = 1; k < 30; k++) step4();
    check_output("loop_a15", a4, 15);
    check_output("loop_pc0", pc4, 0);
    step4();
    step4();
    check_output("loop_a_wrap", a4, 0);
    check_output("loop_pc_exit", pc4, 2);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t  vecs [15];
    arch_t m;
    logic [7:0]  instr4;
    logic [11:0] instr8;
    bit seen;

    vecs[0]  = '{0,  8'h35, 4'h0, 1,  5, 0, 0,  1'b0};
    vecs[1]  = '{1,  8'h79, 4'h0, 2,  5, 9, 0,  1'b0};
    vecs[2]  = '{2,  8'h91, 4'h0, 3,  5, 9, 10, 1'b1};
    vecs[3]  = '{3,  8'h0B, 4'h0, 4,  0, 9, 10, 1'b0};
    vecs[4]  = '{4,  8'hE0, 4'h0, 5,  0, 9, 10, 1'b0};
    vecs[5]  = '{5,  8'hA7, 4'h0, 7,  0, 9, 10, 1'b0};
    vecs[6]  = '{7,  8'h23, 4'h4, 8,  7, 9, 10, 1'b0};
    vecs[7]  = '{8,  8'h6F, 4'h2, 9,  7, 1, 10, 1'b0};
    vecs[8]  = '{9,  8'hA0, 4'h0, 10, 7, 1, 10, 1'b0};
    vecs[9]  = '{10, 8'h12, 4'h0, 11, 3, 1, 10, 1'b0};
    vecs[10] = '{11, 8'h4E, 4'h0, 12, 3, 1, 10, 1'b0};
    vecs[11] = '{12, 8'hB3, 4'h0, 13, 3, 1, 3,  1'b1};
    vecs[12] = '{13, 8'h80, 4'h0, 14, 3, 1, 3,  1'b0};
    vecs[13] = '{14, 8'hFF, 4'h0, 15, 3, 1, 3,  1'b0};
    vecs[14] = '{15, 8'h51, 4'h0, 0,  3, 2, 3,  1'b0};

    // Directed program table
    for (int k = 0; k < 16; k++) mem4[k] = 8'h80;
    mem4[6] = 8'h3F;
    foreach (vecs[i]) mem4[vecs[i].addr] = vecs[i].instr;
    wait4 = 0;
    apply_stimulus_reset4();
    foreach (vecs[i]) begin
      in4 = vecs[i].inp;
      step4();
      check_output("vec_pc", pc4, vecs[i].exp_pc);
      check_output("vec_a", a4, vecs[i].exp_a);
      check_output("vec_b", b4, vecs[i].exp_b);
      check_output("vec_out", out4, vecs[i].exp_out);
      check_output("vec_strobe", strobe4, vecs[i].exp_strobe);
      if (vecs[i].exp_strobe) begin
        @(posedge clk);
        #1;
        check_output("vec_strobe_width", strobe4, 0);
        check_output("vec_out_hold", out4, vecs[i].exp_out);
      end
    end

    // Carry loop, zero-wait and 3-wait memory
    run_carry_loop(0);
    run_carry_loop(3);

    // Halt and resume
    for (int k = 0; k < 16; k++) mem4[k] = 8'h80;
    mem4[5] = 8'hD0;
    mem4[6] = 8'h36;
    wait4 = 0;
    apply_stimulus_reset4();
    for (int k = 0; k < 6; k++) step4();
    check_output("hlt_halted", halted4, 1);
    check_output("hlt_req", req4, 0);
    check_output("hlt_pc", pc4, 6);
    repeat (5) @(negedge clk);
    check_output("hlt_still_halted", halted4, 1);
    check_output("hlt_still_req", req4, 0);
    check_output("hlt_still_pc", pc4, 6);
    check_output("hlt_still_a", a4, 0);
    resume4 = 1'b1;
    @(negedge clk);
    resume4 = 1'b0;
    #1;
    check_output("resume_req", req4, 1);
    check_output("resume_addr", addr4, 6);
    check_output("resume_halted", halted4, 0);
    step4();
    check_output("resume_a", a4, 6);
    check_output("resume_pc", pc4, 7);
    resume4 = 1'b1;
    step4();
    check_output("run_resume_pc", pc4, 8);
    check_output("run_resume_halted", halted4, 0);
    step4();
    check_output("run_resume_pc2", pc4, 9);
    resume4 = 1'b0;

    // Random programs, 4-bit instance
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 16; k++) mem4[k] = 8'($urandom);
      wait4 = 0;
      apply_stimulus_reset4();
      m = '{default: 0};
      for (int k = 0; k < 60; k++) begin
        wait4  = $urandom_range(0, 3);
        in4    = 4'($urandom);
        instr4 = mem4[m.pc];
        m = ref_step(m, int'(instr4[7:4]), int'(instr4[3:0]), int'(in4), 4, 4);
        step4();
        check_arch("rand4", pc4, a4, b4, out4, strobe4, m);
        if (m.halt) begin
          check_output("rand4_halted", halted4, 1);
          @(negedge clk);
          resume4 = 1'b1;
          @(negedge clk);
          resume4 = 1'b0;
        end
      end
    end

    // 8-bit instance: carry/zero from ADD, JZ, JNC and reset during EXEC
    for (int k = 0; k < 64; k++) mem8[k] = 12'h800;
    mem8[0]     = 12'h301;
    mem8[1]     = 12'h0FF;
    mem8[2]     = 12'hA2A;
    mem8[6'h2A] = 12'hE10;
    mem8[6'h2B] = 12'h755;
    wait8 = 0;
    apply_stimulus_reset8();
    step8();
    check_output("w8_mov_a", a8, 8'h01);
    step8();
    check_output("w8_add_a", a8, 8'h00);
    check_output("w8_add_pc", pc8, 2);
    step8();
    check_output("w8_jz_pc", pc8, 6'h2A);
    step8();
    check_output("w8_jnc_pc", pc8, 6'h2B);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (!req8 && !halted8) seen = 1'b1;
    end
    check_output("w8_exec_seen", {31'b0, seen}, 32'd1);
    reset8 = 1'b0;
    @(posedge clk);
    #1;
    check_output("w8_rst_pc", pc8, 0);
    check_output("w8_rst_a", a8, 0);
    check_output("w8_rst_b", b8, 0);
    check_output("w8_rst_out", out8, 0);
    check_output("w8_rst_strobe", strobe8, 0);
    check_output("w8_rst_halted", halted8, 0);
    check_output("w8_rst_req", req8, 1);
    check_output("w8_rst_addr", addr8, 0);
    @(negedge clk);
    reset8 = 1'b1;
    step8();
    check_output("w8_restart_a", a8, 8'h01);
    check_output("w8_restart_pc", pc8, 1);
    check_output("w8_restart_b", b8, 0);

    // Random programs, 8-bit instance
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 64; k++) mem8[k] = 12'($urandom);
      wait8 = 0;
      apply_stimulus_reset8();
      m = '{default: 0};
      for (int k = 0; k < 60; k++) begin
        wait8  = $urandom_range(0, 2);
        in8    = 8'($urandom);
        instr8 = mem8[m.pc];
        m = ref_step(m, int'(instr8[11:8]), int'(instr8[7:0]), int'(in8), 8, 6);
        step8();
        check_arch("rand8", pc8, a8, b8, out8, strobe8, m);
        if (m.halt) begin
          check_output("rand8_halted", halted8, 1);
          @(negedge clk);
          resume8 = 1'b1;
          @(negedge clk);
          resume8 = 1'b0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
